gpreg_mp: RTL

//  Parametrised multi-port general-purpose register file; next generation of the single-write/dual-read gpreg.

---
 rtl/gpreg_mp.sv | 80 ++++++++
 1 files changed

// File: rtl/gpreg_mp.sv
// gpreg_mp: multi-port general-purpose register file with a per-register
// pending scoreboard for hazard detection. x0 always reads zero.
// Optional same-cycle write-to-read bypass is enabled by defining
// GPREG_BYPASS_EN; without it, reads return the stored value only.
module gpreg_mp #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    parameter  int NRD  = 2,
    parameter  int NWR  = 1,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      rd_w,
    input  logic [NWR*AW-1:0]   rd_addr,
    input  logic [NWR*XLEN-1:0] rd,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs,
    output logic [NRD-1:0]      rs_busy,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_addr
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pending;

    // x0 and addresses beyond the implemented register count are never
    // stored, tracked or read back.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && (32'(a) < NREG);
    endfunction

    // Register writeback; later ports override earlier ones on a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) regs[k] <= '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (rd_w[i] && addr_ok(rd_addr[i*AW +: AW]))
                    regs[rd_addr[i*AW +: AW]] <= rd[i*XLEN +: XLEN];
            end
        end
    end

    // Scoreboard: writes retire the producer, issue marks a new one; the
    // issue is applied last so a same-cycle issue leaves the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (rd_w[i] && addr_ok(rd_addr[i*AW +: AW]))
                    pending[rd_addr[i*AW +: AW]] <= 1'b0;
            end
            if (issue_en && addr_ok(issue_addr))
                pending[issue_addr] <= 1'b1;
        end
    end

    // Combinational read ports with busy flags, forced to zero during reset.
    always_comb begin
        rs      = '0;
        rs_busy = '0;
        for (int j = 0; j < NRD; j++) begin
            if (!rst && addr_ok(rs_addr[j*AW +: AW])) begin
                rs[j*XLEN +: XLEN] = regs[rs_addr[j*AW +: AW]];
                rs_busy[j]         = pending[rs_addr[j*AW +: AW]];
`ifdef GPREG_BYPASS_EN
                for (int i = 0; i < NWR; i++) begin
                    if (rd_w[i] && (rd_addr[i*AW +: AW] == rs_addr[j*AW +: AW])) begin
                        rs[j*XLEN +: XLEN] = rd[i*XLEN +: XLEN];
                        rs_busy[j]         = issue_en && (issue_addr == rs_addr[j*AW +: AW]);
                    end
                end
`endif
            end
        end
    end

endmodule
